javk_bus_arb: RTL and testbench

//   Round-robin arbiter and sequencer for the shared JAVK memory bus (16-bit address, 8-bit data, rw).

---
 rtl/javk_bus_arb_pkg.sv | 21 ++
 rtl/javk_bus_arb_rr_pick.sv | 31 +++
 rtl/javk_bus_arb.sv | 164 ++++++++++++++++
 tb/tb_javk_bus_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/javk_bus_arb_pkg.sv
// Shared definitions for the JAVK memory bus arbiter: bus widths,
// arbiter state encoding and a small index-width helper.
package javk_bus_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Read data returned to a requester whose access timed out
  localparam logic [DATA_W-1:0] RDATA_TIMEOUT = 8'hFF;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  // Width needed to index n requester ports (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/javk_bus_arb_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found when searching last+1, last+2, ... (mod NREQ).
module javk_rr_pick
  import javk_bus_arb_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to last+1 so the nearest set request is the one kept
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/javk_bus_arb.sv
// Round-robin arbiter and sequencer for the shared JAVK memory bus.
// One request is captured at a time; the bus strobe stays high until the
// memory signals ready or the wait-state budget runs out. A locked
// requester that keeps req high is reloaded on the ready edge so the bus
// stays busy without an idle cycle.
module javk_bus_arb
  import javk_bus_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int WAIT_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  arb_state_t        state, state_d;
  logic [IDX_W-1:0]  last, last_d;
  logic [IDX_W-1:0]  cur, cur_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic [NREQ-1:0]   gnt_d, done_d, err_d;
  logic [DATA_W-1:0] rdata_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic              load;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = addr[ADDR_W*i +: ADDR_W];
    assign wdata_arr[i] = wdata[DATA_W*i +: DATA_W];
  end

  javk_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Next-state and next-output decode; a requester's fields are loaded through one shared path
  always_comb begin
    state_d     = state;
    last_d      = last;
    cur_d       = cur;
    cnt_d       = cnt;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    load        = 1'b0;
    load_idx    = cur;

    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          load     = 1'b1;
          load_idx = pick_idx;
          state_d  = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (mem_ready) begin
          done_d[cur] = 1'b1;
          last_d      = cur;
          if (!mem_we) begin
            rdata_d = mem_rdata;
          end
          if (lock[cur] && req[cur]) begin
            load     = 1'b1;
            load_idx = cur;
          end else begin
            mem_en_d = 1'b0;
            state_d  = ARB_IDLE;
          end
        end else if (cnt == CNT_LAST) begin
          done_d[cur] = 1'b1;
          err_d[cur]  = 1'b1;
          rdata_d     = RDATA_TIMEOUT;
          mem_en_d    = 1'b0;
          last_d      = cur;
          state_d     = ARB_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (load) begin
      cur_d              = load_idx;
      cnt_d              = '0;
      mem_en_d           = 1'b1;
      mem_we_d           = we[load_idx];
      mem_addr_d         = addr_arr[load_idx];
      mem_wdata_d        = wdata_arr[load_idx];
      gnt_d[load_idx]    = 1'b1;
    end
  end

  // State and registered outputs; reset abandons any access in flight without a done
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      last      <= LAST_RST;
      cur       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      cur       <= cur_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      rdata     <= rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_javk_bus_arb.sv
// Bench for javk_bus_arb: scenario tasks drive the bus and a scoreboard of
// expected completions (port, rdata, err) is checked whenever done pulses.
module tb_javk_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, lock, we;
  logic [47:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, done, err;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  typedef struct {
    int         port;
    logic [7:0] rdata;
    bit         err;
  } sb_t;

  sb_t        exp_q[$];
  logic [7:0] model_rdata;
  int         total = 0;
  int         bad   = 0;

  javk_bus_arb #(
    .NREQ     (3),
    .WAIT_MAX (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected completion; rdata follows the arbiter's hold/overwrite rules
  task automatic push_exp(input int port, input bit is_write, input logic [7:0] rd, input bit to);
    sb_t e;
    if (to) model_rdata = 8'hFF;
    else if (!is_write) model_rdata = rd;
    e.port  = port;
    e.rdata = model_rdata;
    e.err   = to;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b want=000", gnt); end
    total++; if (done !== 3'b000 || err !== 3'b000) begin bad++; $display("FAIL reset_done_err done=%b err=%b want=000", done, err); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", rdata); end
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_en_we en=%b we=%b want=0", mem_en, mem_we); end
    total++; if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_mem_bus addr=%h wdata=%h want=0", mem_addr, mem_wdata); end
    rst = 1'b0;
    model_rdata = 8'h00;
  endtask

  task automatic test_single_read();
    sb_t e;
    req = 3'b001; we = 3'b000; lock = 3'b000;
    addr[15:0] = 16'h1234; mem_ready = 1'b1; mem_rdata = 8'hA5;
    push_exp(0, 1'b0, 8'hA5, 1'b0);
    @(negedge clk);
    total++; if (gnt !== 3'b001) begin bad++; $display("FAIL single_gnt got=%b want=001", gnt); end
    total++; if (mem_en !== 1'b1 || mem_addr !== 16'h1234 || mem_we !== 1'b0) begin bad++; $display("FAIL single_bus en=%b addr=%h we=%b want en=1 addr=1234 we=0", mem_en, mem_addr, mem_we); end
    total++; if (done !== 3'b000) begin bad++; $display("FAIL single_early_done got=%b want=000", done); end
    req = 3'b000;
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL single_sb unexpected done=%b", done); end
    else begin
      e = exp_q.pop_front();
      if (done !== (3'b001 << e.port) || err !== 3'b000 || rdata !== e.rdata) begin
        bad++; $display("FAIL single_sb done=%b err=%b rdata=%h want done=%b err=000 rdata=%h", done, err, rdata, 3'b001 << e.port, e.rdata);
      end
    end
    total++; if (mem_en !== 1'b0 || gnt !== 3'b000) begin bad++; $display("FAIL single_end en=%b gnt=%b want en=0 gnt=000", mem_en, gnt); end
  endtask

  task automatic test_fairness();
    sb_t e;
    int grants = 0;
    int dones = 0;
    int cyc = 0;
    int last_cyc = -1;
    int exp_port = 0;
    do_reset();
    addr = {16'h0C02, 16'h0C01, 16'h0C00}; we = 3'b000; lock = 3'b000;
    mem_ready = 1'b1; mem_rdata = 8'h40;
    req = 3'b111;
    while ((grants < 6 || dones < 6) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (|gnt) begin
        total++; if (gnt !== (3'b001 << exp_port)) begin bad++; $display("FAIL fair_order grant#%0d got=%b want=%b", grants, gnt, 3'b001 << exp_port); end
        total++; if (mem_addr !== 16'h0C00 + 16'(exp_port)) begin bad++; $display("FAIL fair_addr got=%h want=%h", mem_addr, 16'h0C00 + 16'(exp_port)); end
        if (last_cyc >= 0) begin
          total++; if (cyc - last_cyc != 2) begin bad++; $display("FAIL fair_gap got=%0d want=2", cyc - last_cyc); end
        end
        last_cyc = cyc;
        mem_rdata = 8'h40 + 8'(grants);
        push_exp(exp_port, 1'b0, mem_rdata, 1'b0);
        exp_port = (exp_port + 1) % 3;
        grants++;
        if (grants == 6) req = 3'b000;
      end
      if (|done) begin
        dones++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL fair_sb unexpected done=%b", done); end
        else begin
          e = exp_q.pop_front();
          if (done !== (3'b001 << e.port) || err !== 3'b000 || rdata !== e.rdata) begin
            bad++; $display("FAIL fair_sb done=%b err=%b rdata=%h want done=%b err=000 rdata=%h", done, err, rdata, 3'b001 << e.port, e.rdata);
          end
        end
      end
    end
    total++; if (grants != 6 || dones != 6) begin bad++; $display("FAIL fair_timeout grants=%0d dones=%0d want 6/6", grants, dones); end
  endtask

  task automatic test_lock_burst();
    sb_t e;
    logic [2:0]  exp_gnt  [9] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    logic [2:0]  exp_done [9] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    logic        exp_en   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_addr [9] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0, 16'h0A02, 16'h0, 16'h0A00, 16'h0};
    logic [7:0]  exp_wd   [4] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    req = 3'b010; lock = 3'b010; we = 3'b010;
    addr = {16'h0A02, 16'h0100, 16'h0A00}; wdata = {8'h00, 8'hD0, 8'h00};
    mem_ready = 1'b1; mem_rdata = 8'hEE;
    for (int i = 0; i < 4; i++) push_exp(1, 1'b1, 8'h00, 1'b0);
    push_exp(2, 1'b0, 8'h62, 1'b0);
    push_exp(0, 1'b0, 8'h60, 1'b0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      total++; if (gnt !== exp_gnt[c]) begin bad++; $display("FAIL lock_gnt c%0d got=%b want=%b", c + 1, gnt, exp_gnt[c]); end
      total++; if (done !== exp_done[c]) begin bad++; $display("FAIL lock_done c%0d got=%b want=%b", c + 1, done, exp_done[c]); end
      total++; if (mem_en !== exp_en[c]) begin bad++; $display("FAIL lock_en c%0d got=%b want=%b", c + 1, mem_en, exp_en[c]); end
      if (exp_en[c]) begin
        total++; if (mem_addr !== exp_addr[c]) begin bad++; $display("FAIL lock_addr c%0d got=%h want=%h", c + 1, mem_addr, exp_addr[c]); end
      end
      if (c < 4) begin
        total++; if (mem_we !== 1'b1 || mem_wdata !== exp_wd[c]) begin bad++; $display("FAIL lock_wdata c%0d we=%b wdata=%h want we=1 wdata=%h", c + 1, mem_we, mem_wdata, exp_wd[c]); end
      end
      if (|done) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL lock_sb unexpected done=%b", done); end
        else begin
          e = exp_q.pop_front();
          if (done !== (3'b001 << e.port) || err !== 3'b000 || rdata !== e.rdata) begin
            bad++; $display("FAIL lock_sb done=%b err=%b rdata=%h want done=%b err=000 rdata=%h", done, err, rdata, 3'b001 << e.port, e.rdata);
          end
        end
      end
      case (c)
        0: begin addr[31:16] = 16'h0101; wdata[15:8] = 8'hD1; req = 3'b111; we = 3'b010; end
        1: begin addr[31:16] = 16'h0102; wdata[15:8] = 8'hD2; end
        2: begin addr[31:16] = 16'h0103; wdata[15:8] = 8'hD3; end
        3: begin req = 3'b101; lock = 3'b000; end
        5: begin req = 3'b001; mem_rdata = 8'h62; end
        7: begin req = 3'b000; mem_rdata = 8'h60; end
        default: ;
      endcase
    end
  endtask

  task automatic test_timeout();
    sb_t e;
    req = 3'b001; lock = 3'b000; we = 3'b000; addr[15:0] = 16'h2000;
    mem_ready = 1'b0; mem_rdata = 8'h99;
    push_exp(0, 1'b0, 8'h00, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL tmo_gnt got=%b want=001", gnt); end
        req = 3'b000;
      end
      if (c <= 8) begin
        total++; if (mem_en !== 1'b1 || done !== 3'b000) begin bad++; $display("FAIL tmo_wait c%0d en=%b done=%b want en=1 done=000", c, mem_en, done); end
      end else begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL tmo_sb unexpected done=%b", done); end
        else begin
          e = exp_q.pop_front();
          if (done !== (3'b001 << e.port) || err !== (3'b001 << e.port) || rdata !== e.rdata) begin
            bad++; $display("FAIL tmo_sb done=%b err=%b rdata=%h want done=err=%b rdata=%h", done, err, rdata, 3'b001 << e.port, e.rdata);
          end
        end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL tmo_en got=%b want=0", mem_en); end
      end
    end
    req = 3'b100; addr[47:32] = 16'h2002; mem_ready = 1'b1; mem_rdata = 8'h77;
    push_exp(2, 1'b0, 8'h77, 1'b0);
    @(negedge clk);
    total++; if (gnt !== 3'b100 || mem_addr !== 16'h2002) begin bad++; $display("FAIL tmo_next_gnt gnt=%b addr=%h want gnt=100 addr=2002", gnt, mem_addr); end
    req = 3'b000;
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL tmo_next_sb unexpected done=%b", done); end
    else begin
      e = exp_q.pop_front();
      if (done !== (3'b001 << e.port) || err !== 3'b000 || rdata !== e.rdata) begin
        bad++; $display("FAIL tmo_next_sb done=%b err=%b rdata=%h want done=%b err=000 rdata=%h", done, err, rdata, 3'b001 << e.port, e.rdata);
      end
    end
  endtask

  task automatic test_ready_at_limit();
    sb_t e;
    req = 3'b010; we = 3'b000; addr[31:16] = 16'h3001;
    mem_ready = 1'b0; mem_rdata = 8'h5E;
    push_exp(1, 1'b0, 8'h5E, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) req = 3'b000;
      if (c <= 8) begin
        total++; if (done !== 3'b000 || err !== 3'b000) begin bad++; $display("FAIL limit_wait c%0d done=%b err=%b want 000", c, done, err); end
        if (c == 8) mem_ready = 1'b1;
      end else begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL limit_sb unexpected done=%b", done); end
        else begin
          e = exp_q.pop_front();
          if (done !== (3'b001 << e.port) || err !== 3'b000 || rdata !== e.rdata) begin
            bad++; $display("FAIL limit_sb done=%b err=%b rdata=%h want done=%b err=000 rdata=%h", done, err, rdata, 3'b001 << e.port, e.rdata);
          end
        end
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    sb_t e;
    req = 3'b100; we = 3'b000; addr[47:32] = 16'h4002; mem_ready = 1'b0; mem_rdata = 8'h11;
    @(negedge clk);
    total++; if (gnt !== 3'b100 || mem_en !== 1'b1) begin bad++; $display("FAIL rstmid_gnt gnt=%b en=%b want gnt=100 en=1", gnt, mem_en); end
    rst = 1'b1; req = 3'b000;
    @(negedge clk);
    total++; if (mem_en !== 1'b0 || done !== 3'b000 || err !== 3'b000 || gnt !== 3'b000) begin bad++; $display("FAIL rstmid_abort en=%b done=%b err=%b gnt=%b want all 0", mem_en, done, err, gnt); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rstmid_rdata got=%h want=00", rdata); end
    rst = 1'b0; model_rdata = 8'h00;
    req = 3'b111; addr = {16'h4002, 16'h4001, 16'h4000}; mem_ready = 1'b1; mem_rdata = 8'h3A;
    push_exp(0, 1'b0, 8'h3A, 1'b0);
    @(negedge clk);
    total++; if (gnt !== 3'b001 || mem_addr !== 16'h4000 || done !== 3'b000) begin bad++; $display("FAIL rstmid_first gnt=%b addr=%h done=%b want gnt=001 addr=4000 done=000", gnt, mem_addr, done); end
    req = 3'b000;
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL rstmid_sb unexpected done=%b", done); end
    else begin
      e = exp_q.pop_front();
      if (done !== (3'b001 << e.port) || err !== 3'b000 || rdata !== e.rdata) begin
        bad++; $display("FAIL rstmid_sb done=%b err=%b rdata=%h want done=%b err=000 rdata=%h", done, err, rdata, 3'b001 << e.port, e.rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_lock_burst();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    total++; if (exp_q.size() != 0 || done !== 3'b000) begin bad++; $display("FAIL sb_drain left=%0d done=%b want 0", exp_q.size(), done); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
